// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch_stage
//  Description : RV64 decode / operand fetch stage. Decodes the IF/ID
//                instruction and builds its immediate. Selects operands from
//                the register file or from the EX/MEM and MEM/WB forwarding
//                sources. Detects load-use hazards and registers the ID/EX
//                payload.
//  Revision    : 1.0  initial release
// ============================================================================
module operand_fetch_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      RS1,
  output logic [4:0]      RS2,
  input  logic [XLEN-1:0] ReadData1,
  input  logic [XLEN-1:0] ReadData2,
  input  logic            exmem_RegWrite,
  input  logic [4:0]      exmem_RD,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_RegWrite,
  input  logic [4:0]      memwb_RD,
  input  logic [XLEN-1:0] memwb_WriteData,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            stall_out,
  output logic            idex_valid,
  output logic [XLEN-1:0] idex_pc,
  output logic [XLEN-1:0] idex_op1,
  output logic [XLEN-1:0] idex_op2,
  output logic [XLEN-1:0] idex_imm,
  output logic [4:0]      idex_rd,
  output logic [2:0]      idex_funct3,
  output logic [6:0]      idex_opcode,
  output logic            idex_MemRead,
  output logic            idex_MemWrite,
  output logic            idex_RegWrite,
  output logic            idex_Branch,
  output logic            idex_ALUSrc
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;

  logic [6:0]      opcode;
  logic            dec_mem_read;
  logic            dec_mem_write;
  logic            dec_reg_write;
  logic            dec_branch;
  logic            dec_alu_src;
  logic            uses_rs1;
  logic            uses_rs2;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            load_use;

  assign opcode = if_instr[6:0];
  assign RS1    = if_instr[19:15];
  assign RS2    = if_instr[24:20];

  // Operand source: x0 reads zero, then the youngest matching producer wins.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            ex_we,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            wb_we,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] sel;
    if (rs == 5'd0) begin
      sel = '0;
    end else if (ex_we && (ex_rd == rs)) begin
      sel = ex_data;
    end else if (wb_we && (wb_rd == rs)) begin
      sel = wb_data;
    end else begin
      sel = rf_data;
    end
    return sel;
  endfunction

  // Control decode, source-usage flags and immediate generation by opcode.
  always_comb begin
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_reg_write = 1'b0;
    dec_branch    = 1'b0;
    dec_alu_src   = 1'b0;
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    dec_imm       = '0;
    case (opcode)
      OP_LOAD: begin
        dec_mem_read  = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        uses_rs1      = 1'b1;
        dec_imm       = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
      end
      OP_STORE: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec_imm       = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      end
      OP_BRANCH: begin
        dec_branch = 1'b1;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        dec_imm    = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                      if_instr[30:25], if_instr[11:8], 1'b0};
      end
      OP_RTYPE: begin
        dec_reg_write = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_IALU: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        uses_rs1      = 1'b1;
        dec_imm       = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
      end
      default: begin
        dec_mem_read = 1'b0;
      end
    endcase
  end

  // Forwarded operand values for both sources.
  always_comb begin
    op1 = pick_operand(RS1, ReadData1, exmem_RegWrite, exmem_RD, exmem_result,
                       memwb_RegWrite, memwb_RD, memwb_WriteData);
    op2 = pick_operand(RS2, ReadData2, exmem_RegWrite, exmem_RD, exmem_result,
                       memwb_RegWrite, memwb_RD, memwb_WriteData);
  end

  // Load-use hazard: only sources the incoming opcode actually reads count.
  always_comb begin
    load_use = 1'b0;
    if (if_valid && idex_valid && idex_MemRead && (idex_rd != 5'd0)) begin
      load_use = (uses_rs1 && (idex_rd == RS1)) || (uses_rs2 && (idex_rd == RS2));
    end
  end

  // Front-end hold request; a flush or an active reset cancels it.
  always_comb begin
    stall_out = 1'b0;
    if (reset && !flush) begin
      stall_out = ex_stall || load_use;
    end
  end

  // ID/EX register: reset > flush > downstream hold > load-use bubble > advance.
  always_ff @(posedge clk) begin
    if (!reset || flush || (!ex_stall && (load_use || !if_valid))) begin
      idex_valid    <= 1'b0;
      idex_pc       <= '0;
      idex_op1      <= '0;
      idex_op2      <= '0;
      idex_imm      <= '0;
      idex_rd       <= '0;
      idex_funct3   <= '0;
      idex_opcode   <= '0;
      idex_MemRead  <= 1'b0;
      idex_MemWrite <= 1'b0;
      idex_RegWrite <= 1'b0;
      idex_Branch   <= 1'b0;
      idex_ALUSrc   <= 1'b0;
    end else if (!ex_stall) begin
      idex_valid    <= 1'b1;
      idex_pc       <= if_pc;
      idex_op1      <= op1;
      idex_op2      <= op2;
      idex_imm      <= dec_imm;
      idex_rd       <= if_instr[11:7];
      idex_funct3   <= if_instr[14:12];
      idex_opcode   <= opcode;
      idex_MemRead  <= dec_mem_read;
      idex_MemWrite <= dec_mem_write;
      idex_RegWrite <= dec_reg_write;
      idex_Branch   <= dec_branch;
      idex_ALUSrc   <= dec_alu_src;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_fetch_stage
//  Description : Directed vectors with a scoreboard for operand_fetch_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_operand_fetch_stage;

  typedef struct packed {
    logic        v;
    logic [63:0] pc;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic [4:0]  ctl;   // {MemRead, MemWrite, RegWrite, Branch, ALUSrc}
  } rec_t;

  localparam logic [4:0] C_LD = 5'b10101;
  localparam logic [4:0] C_ST = 5'b01001;
  localparam logic [4:0] C_BR = 5'b00010;
  localparam logic [4:0] C_R  = 5'b00100;
  localparam logic [4:0] C_I  = 5'b00101;
  localparam logic [4:0] C_NO = 5'b00000;

  logic        clk = 1'b0;
  logic        reset, if_valid, ex_stall, flush;
  logic [31:0] if_instr;
  logic [63:0] if_pc, ReadData1, ReadData2, exmem_result, memwb_WriteData;
  logic        exmem_RegWrite, memwb_RegWrite;
  logic [4:0]  exmem_RD, memwb_RD;
  logic [4:0]  RS1, RS2;
  logic        stall_out;
  logic        idex_valid;
  logic [63:0] idex_pc, idex_op1, idex_op2, idex_imm;
  logic [4:0]  idex_rd;
  logic [2:0]  idex_funct3;
  logic [6:0]  idex_opcode;
  logic        idex_MemRead, idex_MemWrite, idex_RegWrite, idex_Branch, idex_ALUSrc;

  int   errors = 0;
  int   checks = 0;
  rec_t exp_q[$];
  rec_t zero_rec = '0;
  rec_t last_rec = '0;

  always #5 clk = ~clk;

  operand_fetch_stage #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .RS1(RS1), .RS2(RS2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .exmem_RegWrite(exmem_RegWrite), .exmem_RD(exmem_RD), .exmem_result(exmem_result),
    .memwb_RegWrite(memwb_RegWrite), .memwb_RD(memwb_RD), .memwb_WriteData(memwb_WriteData),
    .ex_stall(ex_stall), .flush(flush), .stall_out(stall_out),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_op1(idex_op1), .idex_op2(idex_op2),
    .idex_imm(idex_imm), .idex_rd(idex_rd), .idex_funct3(idex_funct3), .idex_opcode(idex_opcode),
    .idex_MemRead(idex_MemRead), .idex_MemWrite(idex_MemWrite), .idex_RegWrite(idex_RegWrite),
    .idex_Branch(idex_Branch), .idex_ALUSrc(idex_ALUSrc)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_t(input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {7'b0, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic rec_t mk(input logic v, input logic [63:0] pc, input logic [63:0] op1,
                              input logic [63:0] op2, input logic [63:0] imm,
                              input logic [4:0] rd, input logic [2:0] f3,
                              input logic [6:0] opc, input logic [4:0] ctl);
    rec_t r;
    r.v = v; r.pc = pc; r.op1 = op1; r.op2 = op2; r.imm = imm;
    r.rd = rd; r.f3 = f3; r.opc = opc; r.ctl = ctl;
    return r;
  endfunction

  // Quiet defaults: out of reset, no forwarding, no stalls.
  task automatic idle();
    reset = 1'b1; if_valid = 1'b1; ex_stall = 1'b0; flush = 1'b0;
    exmem_RegWrite = 1'b0; exmem_RD = 5'd0; exmem_result = '0;
    memwb_RegWrite = 1'b0; memwb_RD = 5'd0; memwb_WriteData = '0;
  endtask

  task automatic set_in(input logic [31:0] ins, input logic [63:0] pc,
                        input logic [63:0] rd1, input logic [63:0] rd2);
    if_instr = ins; if_pc = pc; ReadData1 = rd1; ReadData2 = rd2;
  endtask

  // Called at a falling edge with inputs applied: check stall, queue the ID/EX image.
  task automatic step(input string nm, input logic exp_stall, input rec_t e);
    #1;
    chk({nm, ".stall"}, {63'd0, stall_out}, {63'd0, exp_stall});
    exp_q.push_back(e);
    last_rec = e;
    @(negedge clk);
  endtask

  // Monitor: each rising edge with an expectation pending, compare the ID/EX image.
  initial begin
    rec_t e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        #1;
        chk("idex_valid", {63'd0, idex_valid}, {63'd0, e.v});
        chk("idex_ctl", {59'd0, idex_MemRead, idex_MemWrite, idex_RegWrite, idex_Branch,
                         idex_ALUSrc}, {59'd0, e.ctl});
        chk("idex_pc", idex_pc, e.pc);
        chk("idex_op1", idex_op1, e.op1);
        chk("idex_op2", idex_op2, e.op2);
        chk("idex_imm", idex_imm, e.imm);
        chk("idex_fields", {49'd0, idex_rd, idex_funct3, idex_opcode},
            {49'd0, e.rd, e.f3, e.opc});
      end
    end
  end

  initial begin
    logic [31:0] add_541, ld_3, add_4_3;
    add_541 = r_t(5'd2, 5'd1, 3'd0, 5'd5, 7'h33);
    ld_3    = i_t(12'd16, 5'd1, 3'd3, 5'd3, 7'h03);
    add_4_3 = r_t(5'd0, 5'd3, 3'd0, 5'd4, 7'h33);
    idle();
    set_in(add_541, 64'h0, 64'd7, 64'd9);
    reset = 1'b0;
    @(negedge clk);

    // Reset with a valid instruction presented
    chk("rs1_addr", {59'd0, RS1}, 64'd1);
    chk("rs2_addr", {59'd0, RS2}, 64'd2);
    step("reset", 1'b0, zero_rec);

    // Plain add, register-file operands
    idle(); set_in(add_541, 64'h100, 64'd7, 64'd9);
    step("add", 1'b0, mk(1, 64'h100, 64'd7, 64'd9, 64'd0, 5'd5, 3'd0, 7'h33, C_R));

    // Both forwarding sources match rs1: EX/MEM wins
    idle(); set_in(r_t(5'd2, 5'd1, 3'd0, 5'd7, 7'h33), 64'h104, 64'h11, 64'h22);
    exmem_RegWrite = 1; exmem_RD = 5'd1; exmem_result = 64'hAA;
    memwb_RegWrite = 1; memwb_RD = 5'd1; memwb_WriteData = 64'hBB;
    step("fwd_prio", 1'b0, mk(1, 64'h104, 64'hAA, 64'h22, 64'd0, 5'd7, 3'd0, 7'h33, C_R));

    // EX/MEM match but not writing; MEM/WB feeds rs2
    idle(); set_in(r_t(5'd2, 5'd1, 3'd0, 5'd8, 7'h33), 64'h108, 64'h11, 64'h22);
    exmem_RegWrite = 0; exmem_RD = 5'd1; exmem_result = 64'hAA;
    memwb_RegWrite = 1; memwb_RD = 5'd2; memwb_WriteData = 64'hBB;
    step("fwd_wb", 1'b0, mk(1, 64'h108, 64'h11, 64'hBB, 64'd0, 5'd8, 3'd0, 7'h33, C_R));

    // addi x9,x0,5 with producers targeting x0: operand stays 0
    idle(); set_in(i_t(12'd5, 5'd0, 3'd0, 5'd9, 7'h13), 64'h10C, 64'h77, 64'h22);
    exmem_RegWrite = 1; exmem_RD = 5'd0; exmem_result = 64'h55;
    memwb_RegWrite = 1; memwb_RD = 5'd0; memwb_WriteData = 64'h66;
    step("x0_src", 1'b0, mk(1, 64'h10C, 64'd0, 64'h22, 64'd5, 5'd9, 3'd0, 7'h13, C_I));

    // Load then dependent add: one bubble, then forwarded capture
    idle(); set_in(ld_3, 64'h110, 64'h1000, 64'h22);
    step("ld", 1'b0, mk(1, 64'h110, 64'h1000, 64'h22, 64'd16, 5'd3, 3'd3, 7'h03, C_LD));
    idle(); set_in(add_4_3, 64'h114, 64'h5, 64'h6);
    step("lu_stall", 1'b1, zero_rec);
    idle(); set_in(add_4_3, 64'h114, 64'h5, 64'h6);
    exmem_RegWrite = 1; exmem_RD = 5'd3; exmem_result = 64'hDEAD;
    step("lu_resume", 1'b0, mk(1, 64'h114, 64'hDEAD, 64'd0, 64'd0, 5'd4, 3'd0, 7'h33, C_R));

    // Load then I-ALU whose rs2 field equals the load rd: no hazard
    idle(); set_in(i_t(12'd0, 5'd2, 3'd3, 5'd10, 7'h03), 64'h118, 64'h2000, 64'h30);
    step("ld10", 1'b0, mk(1, 64'h118, 64'h2000, 64'd0, 64'd0, 5'd10, 3'd3, 7'h03, C_LD));
    idle(); set_in(i_t(12'd10, 5'd1, 3'd0, 5'd11, 7'h13), 64'h11C, 64'h11, 64'h40);
    step("ialu_rs2", 1'b0, mk(1, 64'h11C, 64'h11, 64'h40, 64'd10, 5'd11, 3'd0, 7'h13, C_I));

    // Load to x0 never stalls
    idle(); set_in(i_t(12'd0, 5'd1, 3'd3, 5'd0, 7'h03), 64'h120, 64'h11, 64'h40);
    step("ld_x0", 1'b0, mk(1, 64'h120, 64'h11, 64'd0, 64'd0, 5'd0, 3'd3, 7'h03, C_LD));
    idle(); set_in(r_t(5'd0, 5'd0, 3'd0, 5'd12, 7'h33), 64'h124, 64'h11, 64'h40);
    step("use_x0", 1'b0, mk(1, 64'h124, 64'd0, 64'd0, 64'd0, 5'd12, 3'd0, 7'h33, C_R));

    // Dependent instruction but if_valid=0: no stall, bubble
    idle(); set_in(ld_3, 64'h128, 64'h1000, 64'h22);
    step("ld_b", 1'b0, mk(1, 64'h128, 64'h1000, 64'h22, 64'd16, 5'd3, 3'd3, 7'h03, C_LD));
    idle(); set_in(add_4_3, 64'h12C, 64'h5, 64'h6); if_valid = 1'b0;
    step("novalid", 1'b0, zero_rec);

    // Flush overrides a load-use stall
    idle(); set_in(ld_3, 64'h130, 64'h1000, 64'h22);
    step("ld_c", 1'b0, mk(1, 64'h130, 64'h1000, 64'h22, 64'd16, 5'd3, 3'd3, 7'h03, C_LD));
    idle(); set_in(add_4_3, 64'h134, 64'h5, 64'h6); flush = 1'b1;
    step("flush_lu", 1'b0, zero_rec);

    // Store reading the load rd through rs2; negative S immediate
    idle(); set_in(ld_3, 64'h138, 64'h1000, 64'h22);
    step("ld_d", 1'b0, mk(1, 64'h138, 64'h1000, 64'h22, 64'd16, 5'd3, 3'd3, 7'h03, C_LD));
    idle(); set_in(s_t(12'hFFC, 5'd3, 5'd1, 3'd3), 64'h13C, 64'h500, 64'h6);
    step("st_stall", 1'b1, zero_rec);
    idle(); set_in(s_t(12'hFFC, 5'd3, 5'd1, 3'd3), 64'h13C, 64'h500, 64'h6);
    exmem_RegWrite = 1; exmem_RD = 5'd3; exmem_result = 64'h99;
    step("st", 1'b0, mk(1, 64'h13C, 64'h500, 64'h99, 64'hFFFF_FFFF_FFFF_FFFC,
                        5'd28, 3'd3, 7'h23, C_ST));

    // Downstream hold keeps the store; then an unknown opcode advances
    idle(); set_in(r_t(5'd2, 5'd1, 3'd0, 5'd5, 7'h37), 64'h140, 64'h1, 64'h2); ex_stall = 1'b1;
    step("ex_hold", 1'b1, last_rec);
    idle(); set_in(r_t(5'd2, 5'd1, 3'd0, 5'd5, 7'h37), 64'h140, 64'h1, 64'h2);
    step("unknown_op", 1'b0, mk(1, 64'h140, 64'h1, 64'h2, 64'd0, 5'd5, 3'd0, 7'h37, C_NO));

    // Flush and downstream hold together
    idle(); set_in(add_541, 64'h144, 64'd7, 64'd9); flush = 1'b1; ex_stall = 1'b1;
    step("flush_hold", 1'b0, zero_rec);

    // Reset during a downstream hold, then a branch with offset -8
    idle(); set_in(add_541, 64'h148, 64'd7, 64'd9);
    step("add_b", 1'b0, mk(1, 64'h148, 64'd7, 64'd9, 64'd0, 5'd5, 3'd0, 7'h33, C_R));
    idle(); set_in(add_541, 64'h14C, 64'd7, 64'd9); ex_stall = 1'b1; reset = 1'b0;
    step("reset_hold", 1'b0, zero_rec);
    idle(); set_in(b_t(-13'sd8, 5'd2, 5'd1, 3'd0), 64'h150, 64'd3, 64'd4);
    step("beq", 1'b0, mk(1, 64'h150, 64'd3, 64'd4, 64'hFFFF_FFFF_FFFF_FFF8,
                         5'd25, 3'd0, 7'h63, C_BR));

    idle(); if_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++; checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_fetch_stage.md
OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width of PC, operands and immediates.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low; sampled on rising clk edge.
REQ-004 if_valid  in  1  IF/ID holds a valid instruction.
REQ-005 if_instr  in  32  RV64 instruction word from IF/ID.
REQ-006 if_pc  in  XLEN  PC of if_instr.
REQ-007 RS1, RS2  out  5  register-file read addresses; combinational = if_instr[19:15], if_instr[24:20].
REQ-008 ReadData1, ReadData2  in  XLEN  register-file read data for RS1/RS2.
REQ-009 exmem_RegWrite, exmem_RD, exmem_result  in  1/5/XLEN  EX/MEM forwarding source.
REQ-010 memwb_RegWrite, memwb_RD, memwb_WriteData  in  1/5/XLEN  MEM/WB forwarding source.
REQ-011 ex_stall  in  1  downstream cannot accept; hold ID/EX.
REQ-012 flush  in  1  taken branch; kill incoming and held instruction.
REQ-013 stall_out  out  1  hold IF/ID and PC this cycle.
REQ-014 idex_valid, idex_pc, idex_op1, idex_op2, idex_imm  out  1/XLEN/XLEN/XLEN/XLEN  registered ID/EX payload.
REQ-015 idex_rd, idex_funct3, idex_opcode  out  5/3/7  registered decode fields.
REQ-016 idex_MemRead, idex_MemWrite, idex_RegWrite, idex_Branch, idex_ALUSrc  out  1 each  registered controls.

Function
REQ-017 Decode by opcode: 0000011 load (MemRead, RegWrite, ALUSrc); 0100011 store (MemWrite, ALUSrc); 1100011 branch (Branch); 0110011 R-type (RegWrite); 0010011 I-ALU (RegWrite, ALUSrc); any other opcode: all controls 0.
REQ-018 Immediate, sign-extended to XLEN: I = instr[31:20]; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}; R/other = 0.
REQ-019 Operand select per source, priority: exmem (RegWrite=1, RD!=0, RD==RSx) > memwb (same rule) > ReadData.
REQ-020 RSx==0 always yields operand 0 regardless of forwarding sources.
REQ-021 Load-use hazard: idex_valid=1, idex_MemRead=1, idex_rd!=0, if_valid=1, and idex_rd equals RS1 or RS2 of an opcode that reads that source (RS2 only for store/branch/R-type) -> stall_out=1.
REQ-022 On load-use stall (ex_stall=0, flush=0): ID/EX loads a bubble (idex_valid=0, all controls 0); next cycle the held instruction proceeds, operand taken via exmem forwarding.
REQ-023 ex_stall=1: all ID/EX registers hold; stall_out=1.
REQ-024 Normal advance: ID/EX captures decode, operands, pc; idex_valid=if_valid; latency one cycle.
REQ-025 flush=1: ID/EX loads bubble and stall_out=0, overriding ex_stall and load-use stall.
REQ-026 Bubble means idex_valid=0 and MemRead/MemWrite/RegWrite/Branch=0; data fields don't-care but driven 0.
REQ-027 if_valid=0: hazard detection inactive; ID/EX loads bubble unless ex_stall.

Reset
REQ-028 reset=0 at a rising edge: all ID/EX outputs 0, idex_valid=0; highest priority over flush and stalls.
REQ-029 stall_out combinational; forced 0 while reset=0.
REQ-030 Reset mid-stall discards held instruction; first valid capture on first edge with reset=1.

Verification
REQ-031 add x5,x1,x2 with ReadData1=7, ReadData2=9, no forwarding -> next cycle idex_valid=1, op1=7, op2=9, RegWrite=1, rd=5.
REQ-032 exmem_RD=1 result=0xAA and memwb_RD=1 data=0xBB, RS1=1 -> idex_op1=0xAA.
REQ-033 ld x3 in ID/EX, incoming add x4,x3,x0 -> stall_out=1 one cycle, bubble in ID/EX, then add captured with op1=exmem_result.
REQ-034 addi x0 source with exmem_RD=0, RegWrite=1, result=0x55 -> op1=0.
REQ-035 flush=1 and ex_stall=1 same cycle -> idex_valid=0 next edge, stall_out=0.
REQ-036 reset=0 during ex_stall with valid payload -> all outputs 0 next edge; beq imm -8 after reset -> idex_imm=0xFFFF_FFFF_FFFF_FFF8.
